// File: rtl/bram_arbiter.sv
// bram_arbiter: round-robin arbiter sharing one BRAM port among NUM_REQ requesters,
// with a one-cycle release phase and an optional watchdog abort.
module bram_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   res,
    input  logic [NUM_REQ*32-1:0]  req_addr,
    input  logic [NUM_REQ*32-1:0]  req_wdata,
    input  logic [NUM_REQ-1:0]     req_read,
    input  logic [NUM_REQ-1:0]     req_write,
    output logic [31:0]            req_rdata,
    output logic [NUM_REQ-1:0]     req_done,
    output logic [NUM_REQ-1:0]     req_err,
    output logic [31:0]            bram_addr,
    output logic [31:0]            bram_wdata,
    output logic                   bram_read,
    output logic                   bram_write,
    input  logic [31:0]            bram_rdata,
    input  logic                   bram_done,
    output logic [NUM_REQ-1:0]     grant
);
    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, RELEASE = 2'd2;
    logic [1:0] state, gi, ptr, win;
    logic [31:0] cnt, g_addr, g_wdata;
    logic [NUM_REQ-1:0] pend;
    logic g_read, g_write, busy, tmo, fin;
    assign pend = req_read | req_write;
    // ptr is the first port to search; fall back to the lowest pending port when none at or above it
    always_comb begin
        win = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (pend[i]) win = 2'(i);
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (pend[i] && 2'(i) >= ptr) win = 2'(i);
    end
    always_comb begin
        g_addr = '0;
        g_wdata = '0;
        g_read = 1'b0;
        g_write = 1'b0;
        for (int i = 0; i < NUM_REQ; i++)
            if (gi == 2'(i)) begin
                g_addr = req_addr[32*i +: 32];
                g_wdata = req_wdata[32*i +: 32];
                g_read = req_read[i];
                g_write = req_write[i];
            end
    end
    assign busy = state == BUSY;
    assign tmo = busy && TIMEOUT != 0 && cnt == 32'(TIMEOUT);
    assign fin = busy && (bram_done || tmo);
    assign bram_addr = busy ? g_addr : '0;
    assign bram_wdata = busy ? g_wdata : '0;
    assign bram_write = busy & g_write;
    assign bram_read = busy & g_read & ~g_write;
    assign req_done = fin ? grant : '0;
    assign req_err = (tmo && !bram_done) ? grant : '0;
    assign req_rdata = (busy && bram_done) ? bram_rdata : '0;
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state <= IDLE;
            grant <= '0;
            gi <= '0;
            ptr <= '0;
            cnt <= '0;
        end else begin
            case (state)
                IDLE: if (|pend) begin
                    state <= BUSY;
                    gi <= win;
                    grant <= NUM_REQ'(1) << win;
                    cnt <= '0;
                end
                BUSY: begin
                    cnt <= &cnt ? cnt : cnt + 32'd1;
                    if (fin) begin
                        state <= RELEASE;
                        ptr <= (gi == 2'(NUM_REQ - 1)) ? 2'd0 : gi + 2'd1;
                    end else if (!(g_read || g_write)) begin
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                    grant <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter: table-driven cycle vectors plus a hand-written reset-mid-access sequence.
module tb_bram_arbiter;
    logic clk = 1'b0, res = 1'b1;
    logic [1:0] rd = '0, wr = '0;
    logic bd = 1'b0;
    logic [31:0] brd = '0;
    logic [63:0] req_addr = {32'h20, 32'h10};
    logic [63:0] req_wdata = {32'hB1B1, 32'hA0A0};
    logic [31:0] req_rdata, bram_addr, bram_wdata;
    logic [1:0] req_done, req_err, grant;
    logic bram_read, bram_write;
    int nv = 0, nf = 0;

    always #5 clk = ~clk;

    bram_arbiter #(.NUM_REQ(2), .TIMEOUT(4)) dut (
        .clk(clk), .res(res), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_read(rd), .req_write(wr), .req_rdata(req_rdata), .req_done(req_done),
        .req_err(req_err), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
        .bram_read(bram_read), .bram_write(bram_write), .bram_rdata(brd),
        .bram_done(bd), .grant(grant)
    );

    typedef struct {
        string nm;
        logic r;
        logic [1:0] rd, wr;
        logic bd;
        logic [31:0] brd;
        logic [1:0] g, dn, er;
        logic br, bw;
        logic [31:0] ba, bwd, rdt;
    } vec_t;
    vec_t vq[$];

    function automatic void row(string n, logic r, logic [1:0] a, logic [1:0] b, logic d,
                                logic [31:0] x, logic [1:0] g, logic [1:0] dn, logic [1:0] er,
                                logic br, logic bw, logic [31:0] rdt);
        vec_t v;
        v.nm = n; v.r = r; v.rd = a; v.wr = b; v.bd = d; v.brd = x;
        v.g = g; v.dn = dn; v.er = er; v.br = br; v.bw = bw; v.rdt = rdt;
        v.ba = (br || bw || g == 2'b01 && dn != 0) ? 32'h0 : 32'h0;
        v.ba = '0; v.bwd = '0;
        vq.push_back(v);
    endfunction
    // BUSY rows: the granted port's address and data must appear on the BRAM side
    function automatic void bz(string n, logic [1:0] a, logic [1:0] b, logic d, logic [31:0] x,
                               logic [1:0] g, logic [1:0] dn, logic [1:0] er, logic br, logic bw,
                               logic [31:0] rdt);
        row(n, 1'b0, a, b, d, x, g, dn, er, br, bw, rdt);
        vq[$].ba = (g == 2'b01) ? 32'h10 : 32'h20;
        vq[$].bwd = (g == 2'b01) ? 32'hA0A0 : 32'hB1B1;
    endfunction
    function automatic void idle(string n, logic [1:0] a, logic [1:0] b);
        row(n, 1'b0, a, b, 1'b0, 32'h0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
    endfunction
    function automatic void rel(string n, logic [1:0] a, logic [1:0] b, logic [1:0] g);
        row(n, 1'b0, a, b, 1'b0, 32'h0, g, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
    endfunction

    task automatic check(string n, logic [103:0] act, logic [103:0] exp);
        nv++;
        if (act !== exp) begin
            nf++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    function automatic logic [103:0] outs();
        return {grant, req_done, req_err, bram_read, bram_write, bram_addr, bram_wdata, req_rdata};
    endfunction

    initial begin
        row("reset", 1'b1, 2'b11, 2'b00, 1'b1, 32'hFFFF, 0, 0, 0, 0, 0, 0);
        idle("c_idle", 0, 3);
        bz("c_p0_wait", 0, 3, 0, 32'h0, 1, 0, 0, 0, 1, 0);
        bz("c_p0_done", 0, 3, 1, 32'h1111, 1, 1, 0, 0, 1, 32'h1111);
        rel("c_rel0", 0, 2, 1);
        idle("c_idle1", 0, 2);
        bz("c_p1_done", 0, 2, 1, 32'h2222, 2, 2, 0, 0, 1, 32'h2222);
        rel("c_rel1", 0, 0, 2);
        for (int k = 0; k < 6; k++) begin
            idle("f_idle", 3, 0);
            bz("f_busy", 3, 0, 1, 32'h100 + k, (k % 2 == 0) ? 2'b01 : 2'b10,
               (k % 2 == 0) ? 2'b01 : 2'b10, 0, 1, 0, 32'h100 + k);
            rel("f_rel", 3, 0, (k % 2 == 0) ? 2'b01 : 2'b10);
        end
        idle("a_idle", 1, 0);
        bz("a_wait", 1, 0, 0, 32'h5A5A, 1, 0, 0, 1, 0, 0);
        bz("a_done", 1, 0, 1, 32'hDEADBEEF, 1, 1, 0, 1, 0, 32'hDEADBEEF);
        rel("a_rel", 0, 0, 1);
        idle("a_end", 0, 0);
        idle("rw_idle", 2, 2);
        bz("rw_busy", 2, 2, 0, 32'h0, 2, 0, 0, 0, 1, 0);
        bz("rw_done", 2, 2, 1, 32'h3333, 2, 2, 0, 0, 1, 32'h3333);
        rel("rw_rel", 0, 0, 2);
        idle("do_idle", 1, 0);
        bz("do_drop", 0, 0, 0, 32'h0, 1, 0, 0, 0, 0, 0);
        rel("do_rel", 0, 0, 1);
        idle("do_arb", 3, 0);
        bz("do_p0", 3, 0, 1, 32'h44, 1, 1, 0, 1, 0, 32'h44);
        rel("do_rel2", 0, 0, 1);
        idle("to_idle", 2, 0);
        for (int k = 0; k < 4; k++) bz("to_wait", 2, 0, 0, 32'hFFFF, 2, 0, 0, 1, 0, 0);
        bz("to_fire", 2, 0, 0, 32'hFFFF, 2, 2, 2, 1, 0, 0);
        rel("to_rel", 0, 0, 2);
        idle("to_next", 1, 0);
        bz("to_next_done", 1, 0, 1, 32'h55, 1, 1, 0, 1, 0, 32'h55);
        rel("to_rel2", 0, 0, 1);
        idle("tc_idle", 2, 0);
        for (int k = 0; k < 4; k++) bz("tc_wait", 2, 0, 0, 32'h0, 2, 0, 0, 1, 0, 0);
        bz("tc_fire", 2, 0, 1, 32'h66, 2, 2, 0, 1, 0, 32'h66);
        rel("tc_rel", 0, 0, 2);
        idle("tc_end", 0, 0);

        foreach (vq[i]) begin
            @(negedge clk);
            res = vq[i].r; rd = vq[i].rd; wr = vq[i].wr; bd = vq[i].bd; brd = vq[i].brd;
            #2;
            check(vq[i].nm, outs(), {vq[i].g, vq[i].dn, vq[i].er, vq[i].br, vq[i].bw,
                                     vq[i].ba, vq[i].bwd, vq[i].rdt});
        end

        // move the pointer to port 1, then reset in the middle of a port-1 read
        @(negedge clk); rd = 2'b01; bd = 1'b0;
        @(negedge clk); bd = 1'b1; brd = 32'h77;
        @(negedge clk); rd = 2'b00; bd = 1'b0;
        @(negedge clk); rd = 2'b10;
        @(negedge clk);
        #2;
        check("rst_busy", {grant, bram_read, bram_addr}, {2'b10, 1'b1, 32'h20});
        res = 1'b1;
        #1;
        check("rst_async", outs(), '0);
        @(negedge clk); res = 1'b0; rd = 2'b11;
        #2;
        check("rst_idle", outs(), '0);
        @(negedge clk);
        #2;
        check("rst_p0_wins", {grant, bram_read, bram_addr}, {2'b01, 1'b1, 32'h10});
        rd = 2'b00;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nv, nf);
        $finish;
    end
endmodule
